// File: rtl/dma_pkg.sv
// Shared DMA constants used by the master and FIFO instances of the DMA block.
package dma_pkg;

    localparam int DMA_DATA_W          = 32;
    localparam int DMA_BURST_LEN       = 16;
    localparam int DMA_FIFO_DEPTH_LOG2 = 9;

endpackage : dma_pkg

// File: rtl/dma_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module dma_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [(1 << ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : dma_fifo_ram

// File: rtl/dma_burst_fifo.sv
// Single-clock FIFO between the DMA read and write masters, with burst-granular
// space/ready flags and one-cycle overflow/underflow pulses.
module dma_burst_fifo
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_DATA_W,
    parameter int DEPTH_LOG2 = DMA_FIFO_DEPTH_LOG2,
    parameter int BURST_LEN  = DMA_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   data_count,
    output logic                  burst_space,
    output logic                  burst_ready,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);

    if (DEPTH < 2 * BURST_LEN) begin : g_bad_cfg
        $error("dma_burst_fifo: DEPTH must be at least 2*BURST_LEN");
    end

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         free_next;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  dout_valid;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_next = data_count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = data_count + CW'(1);
            2'b01:   count_next = data_count - CW'(1);
            default: count_next = data_count;
        endcase
        free_next = DEPTH_C - count_next;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_count  <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            burst_space <= 1'b1;
            burst_ready <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            dout_valid  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + 1'b1;
                dout_valid <= 1'b1;
            end
            data_count  <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == DEPTH_C);
            burst_space <= (free_next >= BURST_C);
            burst_ready <= (count_next >= BURST_C);
            overflow    <= wr_en & full;
            underflow   <= rd_en & empty;
        end
    end

    // The RAM read register has no reset; dout reads as zero until the first
    // read after reset reloads it.
    assign dout = dout_valid ? ram_q : '0;

    dma_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~srst),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_acc & ~srst),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

endmodule : dma_burst_fifo

// File: tb/tb_dma_burst_fifo.sv
// Self-checking bench for dma_burst_fifo against a queue-based reference model.
module tb_dma_burst_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int BURST = 16;

    logic          clk = 1'b0;
    logic          srst;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;
    logic          full;
    logic [DW-1:0] dout;
    logic          empty;
    logic [9:0]    data_count;
    logic          burst_space;
    logic          burst_ready;
    logic          overflow;
    logic          underflow;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_ov;
    logic          m_un;

    always #5 clk = ~clk;

    dma_burst_fifo dut (
        .clk         (clk),
        .srst        (srst),
        .din         (din),
        .wr_en       (wr_en),
        .full        (full),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .data_count  (data_count),
        .burst_space (burst_space),
        .burst_ready (burst_ready),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    logic [47:0] obs;
    assign obs = {dout, data_count, empty, full, burst_space, burst_ready, overflow, underflow};

    function automatic logic [47:0] exp_vec();
        int n;
        n = mq.size();
        return {m_dout, 10'(n), n == 0, n == DEPTH, (DEPTH - n) >= BURST, n >= BURST, m_ov, m_un};
    endfunction

    // Apply one cycle of stimulus, advance the model across the edge, settle.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic s);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        srst  = s;
        @(posedge clk);
        if (s) begin
            mq.delete();
            m_dout = '0;
            m_ov   = 1'b0;
            m_un   = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_ov = w && was_full;
            m_un = r && was_empty;
            if (r && !was_empty) m_dout = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 32'h1234_5678, 1'b1);
        check_cnt++;
        if (obs !== exp_vec())
            $display("FAIL reset_state obs=%h exp=%h", obs, exp_vec());
        else pass_cnt++;
        check_cnt++;
        if ({empty, full, burst_space, burst_ready, data_count} !== {4'b1010, 10'd0})
            $display("FAIL reset_flags got=%b need=%b", {empty, full, burst_space, burst_ready, data_count}, {4'b1010, 10'd0});
        else pass_cnt++;
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 32'h100 + i, 1'b0);
            check_cnt++;
            if (burst_ready !== (i == 15))
                $display("FAIL burst_ready_rise i=%0d got=%b need=%b", i, burst_ready, (i == 15));
            else pass_cnt++;
        end
        check_cnt++;
        if (data_count !== 10'd16 || empty !== 1'b0)
            $display("FAIL burst_fill count=%0d empty=%b need 16/0", data_count, empty);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            check_cnt++;
            if (dout !== 32'h100 + i)
                $display("FAIL burst_read i=%0d got=%h need=%h", i, dout, 32'h100 + i);
            else pass_cnt++;
        end
        check_cnt++;
        if (empty !== 1'b1)
            $display("FAIL burst_empty_after got=%b need=1", empty);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 32'h2000 + i, 1'b0);
            check_cnt++;
            if (burst_space !== ((i + 1) <= DEPTH - BURST) || full !== (i == DEPTH - 1))
                $display("FAIL fill_flags count=%0d bs=%b full=%b need bs=%b full=%b",
                         i + 1, burst_space, full, ((i + 1) <= DEPTH - BURST), (i == DEPTH - 1));
            else pass_cnt++;
        end
        step(1'b1, 1'b0, 32'hBAD0_0001, 1'b0);
        check_cnt++;
        if (overflow !== 1'b1 || data_count !== 10'd512)
            $display("FAIL overflow_pulse ov=%b count=%0d need 1/512", overflow, data_count);
        else pass_cnt++;
        step(1'b0, 1'b0, '0, 1'b0);
        check_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_one_cycle got=%b need=0", overflow);
        else pass_cnt++;
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check_cnt++;
        if (data_count !== 10'd511 || overflow !== 1'b1 || dout !== 32'h2000)
            $display("FAIL full_rdwr count=%0d ov=%b dout=%h need 511/1/00002000", data_count, overflow, dout);
        else pass_cnt++;
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            check_cnt++;
            if (obs !== exp_vec() || dout === 32'hDEAD_BEEF || dout === 32'hBAD0_0001)
                $display("FAIL full_drain i=%0d obs=%h exp=%h", i, obs, exp_vec());
            else pass_cnt++;
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prev;
        prev = dout;
        step(1'b0, 1'b1, '0, 1'b0);
        check_cnt++;
        if (underflow !== 1'b1 || dout !== prev)
            $display("FAIL underflow_pulse un=%b dout=%h need 1/%h", underflow, dout, prev);
        else pass_cnt++;
        step(1'b1, 1'b1, 32'hCAFE_0001, 1'b0);
        check_cnt++;
        if (underflow !== 1'b1 || data_count !== 10'd1 || dout !== prev)
            $display("FAIL empty_rdwr un=%b count=%0d dout=%h need 1/1/%h", underflow, data_count, dout, prev);
        else pass_cnt++;
        step(1'b0, 1'b1, '0, 1'b0);
        check_cnt++;
        if (dout !== 32'hCAFE_0001 || underflow !== 1'b0 || empty !== 1'b1)
            $display("FAIL empty_rdwr_read dout=%h un=%b empty=%b need cafe0001/0/1", dout, underflow, empty);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h3_0000 + i, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'b1, 32'h3_0008 + i, 1'b0);
            check_cnt++;
            if (obs !== exp_vec() || dout !== 32'h3_0000 + i || data_count !== 10'd8 ||
                overflow !== 1'b0 || underflow !== 1'b0)
                $display("FAIL wrap_stream i=%0d obs=%h exp=%h", i, obs, exp_vec());
            else pass_cnt++;
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);
        check_cnt++;
        if (dout !== 32'h3_0000 + 2007 || empty !== 1'b1)
            $display("FAIL wrap_drain dout=%h empty=%b need %h/1", dout, empty, 32'h3_0000 + 2007);
        else pass_cnt++;
    endtask

    task automatic test_srst_mid();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 32'h4_0000 + i, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, 32'h4_FFFF, 1'b1);
        check_cnt++;
        if (data_count !== 10'd0 || empty !== 1'b1 || dout !== 32'h0 || burst_ready !== 1'b0)
            $display("FAIL srst_mid count=%0d empty=%b dout=%h br=%b need 0/1/0/0", data_count, empty, dout, burst_ready);
        else pass_cnt++;
        step(1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0);
        step(1'b1, 1'b0, 32'h5A5A_A5A5, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        check_cnt++;
        if (dout !== 32'hA5A5_5A5A)
            $display("FAIL srst_first_word got=%h need=a5a55a5a", dout);
        else pass_cnt++;
        step(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
            check_cnt++;
            if (obs !== exp_vec())
                $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
            else pass_cnt++;
        end
    endtask

    initial begin
        srst   = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
        m_dout = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
        test_reset();
        test_burst();
        test_fill();
        test_underflow();
        test_back_to_back();
        test_srst_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, check_cnt);
        $fatal(1, "watchdog");
    end

endmodule : tb_dma_burst_fifo
